// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_ctrl_if
// Desc      : Received-byte valid/ready channel plus UART status pulses.
// Rev       : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Desc   : Oversampling UART receiver with start qualification, stop-bit
//          check, break hold-off and a valid/ready output register.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int WIDTH    = 8,
  parameter int BAUD_DIV = 434
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       rx,
  uart_rx_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] C_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             w_rx_s;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_sync        <= 2'b11;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], rx};
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;

      if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= S_START;
            r_baud_cnt <= '0;
            bus.busy   <= 1'b1;
          end
        end

        S_START: begin
          if (r_baud_cnt == C_HALF) begin
            r_baud_cnt <= '0;
            if (w_rx_s) begin
              r_state  <= S_IDLE;
              bus.busy <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_baud_cnt == C_FULL) begin
            r_baud_cnt <= '0;
            r_shreg    <= {w_rx_s, r_shreg[WIDTH-1:1]};
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == C_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_baud_cnt == C_FULL) begin
            r_baud_cnt <= '0;
            if (w_rx_s) begin
              r_state  <= S_IDLE;
              bus.busy <= 1'b0;
              // A same-cycle accept frees the register for the new byte.
              if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= r_shreg;
                bus.rx_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
            end else begin
              r_state       <= S_BREAK;
              bus.frame_err <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          // Hold off start detection until the line has gone idle again.
          if (w_rx_s) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            bus.busy   <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_ctrl
// Desc   : Scoreboarded bench for uart_rx_ctrl at BAUD_DIV=16, WIDTH=8.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int BAUD = 16;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;

  uart_rx_ctrl_if #(.WIDTH(W)) bus ();

  uart_rx_ctrl #(.WIDTH(W), .BAUD_DIV(BAUD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int valid_cycles = 0;
  logic [W-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    rx = 1'b0;
    cycles(BAUD);
    for (int i = 0; i < W; i++) begin
      rx = d[i];
      cycles(BAUD);
    end
    rx = stop;
    cycles(BAUD);
  endtask

  // Output monitor: every accepted byte is compared with the scoreboard head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.rx_valid) valid_cycles++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (sb.size() > 0) check("rx_data", {24'd0, bus.rx_data}, {24'd0, sb.pop_front()});
        else check("spurious_accept", {31'd0, bus.rx_valid && bus.rx_ready}, 32'd0);
      end
    end
  end

  int base;

  initial begin
    bus.rx_ready = 1'b0;
    cycles(4);
    check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_data",  {24'd0, bus.rx_data}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, bus.overrun}, 32'd0);
    reset_n = 1'b1;
    cycles(4);

    // Single frame, normal accept
    bus.rx_ready = 1'b1;
    valid_cycles = 0;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    cycles(4);
    check("valid_one_cycle", valid_cycles, 1);
    check("a5_ferr", ferr_cnt, 0);

    // False start
    base = ferr_cnt;
    rx = 1'b0;
    cycles(5);
    check("fs_busy_mid", {31'd0, bus.busy}, 32'd1);
    rx = 1'b1;
    cycles(8);
    check("fs_busy", {31'd0, bus.busy}, 32'd0);
    check("fs_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("fs_ferr", ferr_cnt, base);
    cycles(10);

    // Framing error then held-low line
    base = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    cycles(40);
    check("fe_busy_break", {31'd0, bus.busy}, 32'd1);
    check("fe_count", ferr_cnt, base + 1);
    check("fe_valid", {31'd0, bus.rx_valid}, 32'd0);
    rx = 1'b1;
    cycles(10);
    check("fe_busy_after", {31'd0, bus.busy}, 32'd0);
    check("fe_count_after", ferr_cnt, base + 1);

    // Overrun: second byte lost while first is pending
    bus.rx_ready = 1'b0;
    base = ovr_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cycles(2);
    check("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("ovr_data", {24'd0, bus.rx_data}, 32'h11);
    check("ovr_count", ovr_cnt, base + 1);
    bus.rx_ready = 1'b1;
    cycles(1);
    check("ovr_drop", {31'd0, bus.rx_valid}, 32'd0);
    bus.rx_ready = 1'b0;
    cycles(4);

    // Accept-and-load in the completion cycle of the next frame
    base = ovr_cnt;
    sb.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    cycles(4);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        cycles(154);
        bus.rx_ready = 1'b1;
        cycles(1);
        bus.rx_ready = 1'b0;
      end
    join
    cycles(2);
    check("sim_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("sim_data", {24'd0, bus.rx_data}, 32'h22);
    check("sim_no_ovr", ovr_cnt, base);
    bus.rx_ready = 1'b1;
    cycles(2);
    bus.rx_ready = 1'b0;
    cycles(4);

    // Reset during data bit 3 with a pending byte held
    send_frame(8'h77, 1'b1);
    cycles(4);
    rx = 1'b0;
    cycles(BAUD);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h5A >> i) & 1;
      cycles(BAUD);
    end
    rx = 1'b1;
    cycles(BAUD / 2);
    reset_n = 1'b0;
    cycles(1);
    check("mr_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mr_data",  {24'd0, bus.rx_data}, 32'd0);
    check("mr_busy",  {31'd0, bus.busy}, 32'd0);
    check("mr_ferr",  {31'd0, bus.frame_err}, 32'd0);
    check("mr_ovr",   {31'd0, bus.overrun}, 32'd0);
    reset_n = 1'b1;
    cycles(20);
    base = ferr_cnt;
    bus.rx_ready = 1'b1;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    cycles(4);
    check("mr_no_ferr", ferr_cnt, base);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
